// File: rtl/aes_sbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox_pkg
// Description : AES (FIPS-197) forward and inverse S-box tables plus lookup
//               helpers shared by the byte-substitution datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_sbox_pkg;

    localparam int BYTE_W = 8;

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return SBOX_FWD[b];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return SBOX_INV[b];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_lane.sv
`default_nettype none
// ============================================================================
// Module      : sbox_lane
// Description : Single-byte combinational AES S-box lookup. With
//               SBOX_ARRAY_INV_EN defined, inv=1 selects the inverse S-box;
//               otherwise only the forward table is built and inv is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_lane
    import aes_sbox_pkg::*;
(
    input  logic [BYTE_W-1:0] din,
    input  logic              inv,
    output logic [BYTE_W-1:0] dout
);

`ifdef SBOX_ARRAY_INV_EN
    // Per-byte table select between forward and inverse substitution
    always_comb begin
        dout = inv ? sbox_inv(din) : sbox_fwd(din);
    end
`else
    // Forward-only build: the mode input has no effect
    logic w_unused_inv;
    assign w_unused_inv = inv;

    always_comb begin
        dout = sbox_fwd(din);
    end
`endif

endmodule
`default_nettype wire

// File: rtl/sbox_array_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sbox_array_pipe
// Description : Pipelined AES byte-substitution engine. LANES bytes are
//               substituted per beat, registered into stage 1 and retimed
//               through PIPE_STAGES stages under a valid/ready handshake.
//               Optional inverse mode: SBOX_ARRAY_INV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_array_pipe
    import aes_sbox_pkg::*;
#(
    parameter int LANES       = 16,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BYTE_W*LANES-1:0] in_data,
    input  logic                    in_inv,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BYTE_W*LANES-1:0] out_data,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    busy
);

    localparam int DATA_W = BYTE_W * LANES;

    logic [DATA_W-1:0]      w_sub;
    logic                   w_inv;
    logic [PIPE_STAGES:0]   w_load;

    logic [PIPE_STAGES-1:0] r_vld;
    logic [DATA_W-1:0]      r_data [PIPE_STAGES];
    logic [TAG_W-1:0]       r_tag  [PIPE_STAGES];

`ifdef SBOX_ARRAY_INV_EN
    // The mode bit travels with its beat; the substitution already happened
    // at the input, so the last stage's copy is informational only.
    logic [PIPE_STAGES-1:0] r_inv;
    logic                   w_unused_mode;
    assign w_inv         = in_inv;
    assign w_unused_mode = r_inv[PIPE_STAGES-1];
`else
    logic w_unused_in_inv;
    assign w_inv           = 1'b0;
    assign w_unused_in_inv = in_inv;
`endif

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            sbox_lane u_lane (
                .din  (in_data[i*BYTE_W +: BYTE_W]),
                .inv  (w_inv),
                .dout (w_sub[i*BYTE_W +: BYTE_W])
            );
        end
    endgenerate

    // Load enables ripple back from out_ready: a stage loads when empty or
    // when its contents are leaving this cycle, so bubbles collapse.
    always_comb begin
        w_load                = '0;
        w_load[PIPE_STAGES]   = out_ready;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            w_load[k] = ~r_vld[k] | w_load[k+1];
        end
    end

    assign in_ready  = reset & w_load[0];
    assign out_valid = r_vld[PIPE_STAGES-1];
    assign out_data  = r_data[PIPE_STAGES-1];
    assign out_tag   = r_tag[PIPE_STAGES-1];
    assign busy      = |r_vld;

    // Stage registers: stage 1 captures substituted input, later stages retime
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vld <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                r_data[k] <= '0;
                r_tag[k]  <= '0;
            end
`ifdef SBOX_ARRAY_INV_EN
            r_inv <= '0;
`endif
        end else begin
            if (w_load[0]) begin
                r_vld[0] <= in_valid;
                if (in_valid) begin
                    r_data[0] <= w_sub;
                    r_tag[0]  <= in_tag;
`ifdef SBOX_ARRAY_INV_EN
                    r_inv[0]  <= in_inv;
`endif
                end
            end
            for (int k = 1; k < PIPE_STAGES; k++) begin
                if (w_load[k]) begin
                    r_vld[k] <= r_vld[k-1];
                    if (r_vld[k-1]) begin
                        r_data[k] <= r_data[k-1];
                        r_tag[k]  <= r_tag[k-1];
`ifdef SBOX_ARRAY_INV_EN
                        r_inv[k]  <= r_inv[k-1];
`endif
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sbox_array_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sbox_array_pipe
// Description : Self-checking bench for sbox_array_pipe. Reference S-box is
//               derived from GF(2^8) inversion plus the AES affine map.
//               Optional inverse mode: SBOX_ARRAY_INV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sbox_array_pipe;

`ifdef SBOX_ARRAY_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         in_valid, in_ready, in_inv;
    logic [127:0] in_data;
    logic [3:0]   in_tag;
    logic         out_valid, out_ready, busy;
    logic [127:0] out_data;
    logic [3:0]   out_tag;

    logic         sw_valid, sw_inv, sw_out_ready;
    logic [31:0]  sw_data;
    logic [3:0]   sw_tag;
    logic         s1_in_ready, s1_out_valid, s1_busy;
    logic [31:0]  s1_out_data;
    logic [3:0]   s1_out_tag;
    logic         s4_in_ready, s4_out_valid, s4_busy;
    logic [31:0]  s4_out_data;
    logic [3:0]   s4_out_tag;

    sbox_array_pipe #(.LANES(16), .PIPE_STAGES(2), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .busy(busy)
    );

    sbox_array_pipe #(.LANES(4), .PIPE_STAGES(1), .TAG_W(4)) dut_s1 (
        .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(s1_in_ready),
        .in_data(sw_data), .in_inv(sw_inv), .in_tag(sw_tag),
        .out_valid(s1_out_valid), .out_ready(sw_out_ready), .out_data(s1_out_data),
        .out_tag(s1_out_tag), .busy(s1_busy)
    );

    sbox_array_pipe #(.LANES(4), .PIPE_STAGES(4), .TAG_W(4)) dut_s4 (
        .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(s4_in_ready),
        .in_data(sw_data), .in_inv(sw_inv), .in_tag(sw_tag),
        .out_valid(s4_out_valid), .out_ready(sw_out_ready), .out_data(s4_out_data),
        .out_tag(s4_out_tag), .busy(s4_busy)
    );

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   t;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_fwd [256];
    logic [7:0] ref_inv [256];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_out    = 0;
    int         cyc      = 0;
    int         last_xfer_cyc = -10;
    int         run_len  = 0;
    int         max_run  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = (b << n) | (b >> (8 - n));
        return r;
    endfunction

    function automatic logic [127:0] exp_word(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        r = '0;
        for (int l = 0; l < 16; l++)
            r[8*l +: 8] = inv ? ref_inv[d[8*l +: 8]] : ref_fwd[d[8*l +: 8]];
        return r;
    endfunction

    // Scoreboard: push on accepted input, pop and compare on output transfer
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                exp_t e;
                n_out++;
                run_len = (cyc == last_xfer_cyc + 1) ? run_len + 1 : 1;
                last_xfer_cyc = cyc;
                if (run_len > max_run) max_run = run_len;
                check("beat_expected", 128'(sb.size() != 0), 128'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_tag", 128'(out_tag), 128'(e.t));
                end
            end
            if (in_valid && in_ready)
                sb.push_back('{d: exp_word(in_data, in_inv & INV_EN), t: in_tag});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [127:0] d, input logic inv, input logic [3:0] t);
        int  w;
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        in_tag   = t;
        w = 0;
        do begin
            #3;
            acc = in_ready;
            tick();
            w++;
        end while (!acc && w < 200);
        check("send_accept", 128'(acc), 128'd1);
    endtask

    task automatic drain(input int target);
        int w;
        w = 0;
        in_valid = 1'b0;
        while ((n_out < target || sb.size() != 0) && w < 500) begin
            tick();
            w++;
        end
        check("drain_count", 128'(n_out), 128'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        int           n0, c0;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] xi, s;
            xi = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
            s = xi ^ rotl(xi, 1) ^ rotl(xi, 2) ^ rotl(xi, 3) ^ rotl(xi, 4) ^ 8'h63;
            ref_fwd[x] = s;
            ref_inv[s] = 8'(x);
        end

        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; in_tag = '0;
        out_ready = 1'b1;
        sw_valid = 1'b0; sw_data = '0; sw_inv = 1'b0; sw_tag = '0; sw_out_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        #3;
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        tick();
        reset = 1'b1;
        #3;
        check("post_rst_in_ready", 128'(in_ready), 128'd1);
        tick();

        // Single forward beat with latency and tag echo
        d = {{12{8'h01}}, 8'h52, 8'hff, 8'h53, 8'h00};
        send(d, 1'b0, 4'h5);
        in_valid = 1'b0;
        #3;
        check("lat_early_valid", 128'(out_valid), 128'd0);
        tick();
        #3;
        check("lat_valid", 128'(out_valid), 128'd1);
        check("single_lo", 128'(out_data[31:0]), 128'(32'h0016ed63));
        check("single_hi", 128'(out_data[127:32]), 128'({12{8'h7c}}));
        check("single_tag", 128'(out_tag), 128'h5);
        tick();
        drain(1);

        // Mode input: inverse when enabled, ignored otherwise
        n0 = n_out;
        d = {96'h0, 8'h7c, 8'h16, 8'hed, 8'h63};
        send(d, 1'b1, 4'h6);
        in_valid = 1'b0;
        tick();
        #3;
        check("mode_valid", 128'(out_valid), 128'd1);
`ifdef SBOX_ARRAY_INV_EN
        check("mode_inv_lanes", 128'(out_data[31:0]), 128'(32'h01ff5300));
`else
        check("mode_fwd_lanes", 128'(out_data[31:0]), 128'(32'h104755fb));
`endif
        tick();
        for (int i = 0; i < 8; i++)
            send({$urandom, $urandom, $urandom, $urandom}, i[0], 4'(i));
        drain(n0 + 9);

        // Backpressure: fill with out_ready low, then release
        n0 = n_out;
        out_ready = 1'b0;
        send({4{32'h11223344}}, 1'b0, 4'h1);
        send({4{32'h55667788}}, 1'b0, 4'h2);
        in_valid = 1'b1; in_data = {4{32'h99aabbcc}}; in_tag = 4'h3; in_inv = 1'b0;
        #3;
        check("bp_in_ready_low", 128'(in_ready), 128'd0);
        check("bp_busy", 128'(busy), 128'd1);
        for (int k = 0; k < 3; k++) begin
            check("bp_hold_data", out_data, exp_word({4{32'h11223344}}, 1'b0));
            check("bp_hold_tag", 128'(out_tag), 128'h1);
            tick();
            #3;
        end
        tick();
        out_ready = 1'b1;
        send({4{32'h99aabbcc}}, 1'b0, 4'h3);
        send({4{32'hddeeff00}}, 1'b0, 4'h4);
        send({4{32'h0f1e2d3c}}, 1'b0, 4'h5);
        drain(n0 + 5);

        // Full throughput: 256 beats back to back
        n0 = n_out;
        max_run = 0;
        c0 = cyc;
        for (int i = 0; i < 256; i++) begin
            for (int l = 0; l < 16; l++) d[8*l +: 8] = 8'(i + 17 * l);
            send(d, 1'b0, 4'(i));
        end
        check("tp_accept_cycles", 128'(cyc - c0), 128'd256);
        drain(n0 + 256);
        check("tp_run_len", 128'(max_run), 128'd256);

        // Reset with two beats in flight
        n0 = n_out;
        out_ready = 1'b0;
        send({4{32'hcafef00d}}, 1'b0, 4'ha);
        send({4{32'hdeadbeef}}, 1'b0, 4'hb);
        in_valid = 1'b0;
        reset = 1'b0;
        #3;
        check("mid_rst_in_ready", 128'(in_ready), 128'd0);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        #3;
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_out_data", out_data, 128'd0);
        check("mid_rst_in_ready_rel", 128'(in_ready), 128'd1);
        repeat (6) tick();
        check("mid_rst_no_beats", 128'(n_out), 128'(n0));
        check("mid_rst_sb_empty", 128'(sb.size()), 128'd0);

        // Parameter sweep: LANES=4 with 1 and 4 stages
        sw_valid = 1'b1; sw_data = 32'h0053ff52; sw_tag = 4'h9;
        #3;
        check("sw_in_ready_1", 128'(s1_in_ready), 128'd1);
        check("sw_in_ready_4", 128'(s4_in_ready), 128'd1);
        tick();
        sw_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #3;
            check("sw1_valid", 128'(s1_out_valid), 128'(k == 1));
            check("sw4_valid", 128'(s4_out_valid), 128'(k == 4));
            if (k == 1) begin
                check("sw1_data", 128'(s1_out_data), 128'(32'h63ed1600));
                check("sw1_tag", 128'(s1_out_tag), 128'h9);
            end
            if (k == 4) begin
                check("sw4_data", 128'(s4_out_data), 128'(32'h63ed1600));
                check("sw4_tag", 128'(s4_out_tag), 128'h9);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sbox_array_pipe.md
Name: sbox_array_pipe

Overview:
- Parametrised, pipelined AES byte-substitution engine: applies the AES S-box to LANES bytes in parallel per beat.
- Intended users:
  - Round datapath SubBytes: 16 lanes.
  - Key-expansion SubWord: 4 lanes.
- valid/ready handshake; stalls propagate with no data loss; full throughput of one beat per cycle.
- Optional inverse S-box mode for the decryption datapath.

Parameters:
- LANES, 16, number of byte lanes substituted per beat (legal 1..16).
- PIPE_STAGES, 2, register stages from input to output (legal 1..4).
- TAG_W, 4, width of the sideband tag carried alongside the data (legal 1..16).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat this cycle.
- in_data  in  8*LANES  input bytes; lane i = in_data[8i+7:8i].
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box; captured per beat.
- in_tag  in  TAG_W  opaque sideband, returned unchanged with its beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  8*LANES  substituted bytes; lane i maps to input lane i.
- out_tag  out  TAG_W  tag of the output beat.
- busy  out  1  any pipeline stage holds a valid beat.

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Pipeline structure:
  - Stages 1..PIPE_STAGES, each holding {vld, data, inv, tag}.
  - Substitution is combinational on in_data and is registered into stage 1; later stages are pure retiming.
- Per-stage movement:
  - Stage k may load when it is empty, or when stage k+1 loads / the output transfers in this same cycle.
  - in_ready = stage 1 may load. It is combinational from out_ready through the chain; there is no skid buffer.
- Latency: an accepted beat appears on out_valid exactly PIPE_STAGES cycles later if there is no stall. Throughput is 1 beat/cycle under continuous out_ready.
- Stall behaviour:
  - With out_ready=0, the pipeline fills; in_ready drops once all PIPE_STAGES are full.
  - out_data and out_tag hold stable while out_valid=1 and out_ready=0.
- Bubbles: interior bubbles collapse. An empty stage loads even when the downstream stage is stalled.
- Simultaneous events: input and output transfer in the same cycle with a full pipeline is legal; occupancy is unchanged and there are no drops.
- Mode:
  - in_inv is sampled with each beat, so forward and inverse beats may interleave back-to-back.
  - The result is FIPS-197 S-box / InvS-box per lane.
- busy = OR of all stage vld bits.
- Reset (synchronous, reset==0 at a clk edge):
  - All vld bits, out_data, out_tag and busy go to 0.
  - in_ready is forced to 0 while reset==0 and becomes 1 on the first cycle after release.
  - Reset mid-stream discards all in-flight beats; no partial beat is emitted.
- Width rules:
  - No arithmetic is performed; each lane is independent.
  - LANES=1 is a degenerate single-byte path with identical timing.

Optional Feature:
- Macro: SBOX_ARRAY_INV_EN.
- Defined:
  - The inverse table is instantiated.
  - in_inv=1 selects InvS-box per beat.
- Undefined:
  - No inverse table is built; in_inv is ignored and always treated as 0.
  - The inv bit is not stored in the stages.
  - Timing and handshake are otherwise identical.

Decomposition:
- Package aes_sbox_pkg holds:
  - The 256-entry forward and inverse S-box constant arrays.
  - Function sbox_fwd(byte) and sbox_inv(byte).
  - Localparam BYTE_W=8.
- Sub-module sbox_lane:
  - One-byte combinational lookup with inputs din[7:0] and inv, and output dout[7:0].
  - Instantiated LANES times via generate.
- Pipeline control stays in the top module.

Test Plan:
- Single beat, LANES=16, PIPE_STAGES=2, in_inv=0:
  - Stimulus: lane0=00, lane1=53, lane2=ff, lane3=52, other lanes = 01.
  - Required: out_data lanes = 63, ed, 16, 00, 7c…, arriving exactly 2 cycles after acceptance, with tag echoed.
- Inverse mode (SBOX_ARRAY_INV_EN defined):
  - Stimulus: lanes 63, ed, 16, 7c with in_inv=1.
  - Required: out lanes 00, 53, ff, 01. Then alternate inv=0/1 on back-to-back beats and check that each result matches its own mode.
- Backpressure:
  - Stimulus: out_ready=0 while streaming tags 1..5 with PIPE_STAGES=2.
  - Required: in_ready falls after 2 beats are accepted; out_data is stable. Release out_ready and check tags 1..5 emerge in order with no loss or duplication.
- Full throughput:
  - Stimulus: 256 beats with lane0 = 00..ff and out_ready=1.
  - Required: out_valid is continuous for 256 cycles and lane0 matches the FIPS-197 table for every value.
- Reset mid-operation:
  - Stimulus: assert reset=0 for 1 cycle with 2 beats in flight.
  - Required: the next cycle shows out_valid=0, busy=0, out_data=0; those beats never appear; in_ready=1 after release.
- Parameter sweep:
  - Stimulus: LANES=4 with PIPE_STAGES=1, then PIPE_STAGES=4; input word 00_53_ff_52.
  - Required: output 63_ed_16_00 with latency 1 and 4 respectively.
